// File: rtl/tl_ul_dma_initiator.sv
// tl_ul_dma_initiator: TileLink-UL word-copy DMA master, one transaction outstanding.
// Define DMA_FILL_EN to add pattern-fill mode (cmd_fill/cmd_pattern).
module tl_ul_dma_initiator #(
  parameter int TL_SW     = 1,
  parameter int SOURCE_ID = 0,
  parameter int LEN_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_src,
  input  logic [31:0]      cmd_dst,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_fill,
  input  logic [31:0]      cmd_pattern,
  output logic             done,
  output logic             error,
  output logic             busy,
  output logic [2:0]       tl_a_opcode,
  output logic [2:0]       tl_a_param,
  output logic [3:0]       tl_a_size,
  output logic [TL_SW-1:0] tl_a_source,
  output logic [31:0]      tl_a_address,
  output logic [3:0]       tl_a_mask,
  output logic [31:0]      tl_a_data,
  output logic             tl_a_corrupt,
  output logic             tl_a_valid,
  input  logic             tl_a_ready,
  input  logic [2:0]       tl_d_opcode,
  input  logic [1:0]       tl_d_param,
  input  logic [3:0]       tl_d_size,
  input  logic [TL_SW-1:0] tl_d_source,
  input  logic             tl_d_denied,
  input  logic [31:0]      tl_d_data,
  input  logic             tl_d_corrupt,
  input  logic             tl_d_valid,
  output logic             tl_d_ready
);
  typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_RSP, S_WR_REQ, S_WR_RSP, S_FIN} state_t;
  localparam logic [2:0] OP_GET = 3'd4;
  localparam logic [2:0] OP_PUT = 3'd0;
  state_t           r_state;
  logic [31:0]      r_src, r_dst, r_data, r_addr;
  logic [LEN_W-1:0] r_len;
  logic [2:0]       r_opcode;
  logic             r_error, r_done, r_busy, r_cmd_ready, r_a_valid, r_d_ready, r_fill;
  logic [31:0]      w_src, w_dst, w_src_nxt, w_dst_nxt;
  logic             w_fill, w_unused;
  assign w_src     = {cmd_src[31:2], 2'b00};
  assign w_dst     = {cmd_dst[31:2], 2'b00};
  assign w_src_nxt = r_src + 32'd4;
  assign w_dst_nxt = r_dst + 32'd4;
`ifdef DMA_FILL_EN
  assign w_fill = cmd_fill;
`else
  assign w_fill = 1'b0;
`endif
  // D-channel echo fields are not checked: with one transaction outstanding the response always matches
  assign w_unused = ^{cmd_fill, cmd_src[1:0], cmd_dst[1:0], tl_d_opcode, tl_d_param, tl_d_size, tl_d_source};
  assign cmd_ready    = r_cmd_ready;
  assign done         = r_done;
  assign error        = r_error;
  assign busy         = r_busy;
  assign tl_a_opcode  = r_opcode;
  assign tl_a_param   = 3'd0;
  assign tl_a_size    = 4'd2;
  assign tl_a_source  = TL_SW'(SOURCE_ID);
  assign tl_a_address = r_addr;
  assign tl_a_mask    = 4'hF;
  assign tl_a_data    = r_data;
  assign tl_a_corrupt = 1'b0;
  assign tl_a_valid   = r_a_valid;
  assign tl_d_ready   = r_d_ready;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_len       <= '0;
      r_data      <= '0;
      r_addr      <= '0;
      r_opcode    <= OP_GET;
      r_fill      <= 1'b0;
      r_error     <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_a_valid   <= 1'b0;
      r_d_ready   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (cmd_valid) begin
          r_src       <= w_src;
          r_dst       <= w_dst;
          r_len       <= cmd_len;
          r_fill      <= w_fill;
          r_error     <= 1'b0;
          r_cmd_ready <= 1'b0;
          r_busy      <= 1'b1;
          if (cmd_len == '0) begin
            r_state <= S_FIN;
            r_done  <= 1'b1;
          end else if (w_fill) begin
            r_state   <= S_WR_REQ;
            r_a_valid <= 1'b1;
            r_opcode  <= OP_PUT;
            r_addr    <= w_dst;
            r_data    <= cmd_pattern;
          end else begin
            r_state   <= S_RD_REQ;
            r_a_valid <= 1'b1;
            r_opcode  <= OP_GET;
            r_addr    <= w_src;
          end
        end
        S_RD_REQ: if (tl_a_ready) begin
          r_state   <= S_RD_RSP;
          r_a_valid <= 1'b0;
          r_d_ready <= 1'b1;
        end
        S_RD_RSP: if (tl_d_valid) begin
          r_d_ready <= 1'b0;
          r_data    <= tl_d_data;
          if (tl_d_denied || tl_d_corrupt) begin
            r_error <= 1'b1;
            r_state <= S_FIN;
            r_done  <= 1'b1;
          end else begin
            r_state   <= S_WR_REQ;
            r_a_valid <= 1'b1;
            r_opcode  <= OP_PUT;
            r_addr    <= r_dst;
          end
        end
        S_WR_REQ: if (tl_a_ready) begin
          r_state   <= S_WR_RSP;
          r_a_valid <= 1'b0;
          r_d_ready <= 1'b1;
        end
        S_WR_RSP: if (tl_d_valid) begin
          r_d_ready <= 1'b0;
          if (tl_d_denied) begin
            r_error <= 1'b1;
            r_state <= S_FIN;
            r_done  <= 1'b1;
          end else begin
            r_src <= w_src_nxt;
            r_dst <= w_dst_nxt;
            r_len <= r_len - LEN_W'(1);
            if (r_len == LEN_W'(1)) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state   <= r_fill ? S_WR_REQ : S_RD_REQ;
              r_a_valid <= 1'b1;
              r_opcode  <= r_fill ? OP_PUT : OP_GET;
              r_addr    <= r_fill ? w_dst_nxt : w_src_nxt;
            end
          end
        end
        S_FIN: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tl_ul_dma_initiator.sv
// tb_tl_ul_dma_initiator: randomized TileLink slave plus transaction-level model of expected A beats.
module tb_tl_ul_dma_initiator;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_fill = 1'b0;
  logic [31:0] cmd_src = '0, cmd_dst = '0, cmd_pattern = '0;
  logic [15:0] cmd_len = '0;
  logic        done, error, busy;
  logic [2:0]  tl_a_opcode, tl_a_param;
  logic [3:0]  tl_a_size, tl_a_mask;
  logic [0:0]  tl_a_source;
  logic [31:0] tl_a_address, tl_a_data;
  logic        tl_a_corrupt, tl_a_valid, tl_a_ready;
  logic [2:0]  tl_d_opcode;
  logic [1:0]  tl_d_param;
  logic [3:0]  tl_d_size;
  logic [0:0]  tl_d_source;
  logic        tl_d_denied, tl_d_corrupt, tl_d_valid, tl_d_ready;
  logic [31:0] tl_d_data;

  tl_ul_dma_initiator dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_fill(cmd_fill),
    .cmd_pattern(cmd_pattern), .done(done), .error(error), .busy(busy),
    .tl_a_opcode(tl_a_opcode), .tl_a_param(tl_a_param), .tl_a_size(tl_a_size),
    .tl_a_source(tl_a_source), .tl_a_address(tl_a_address), .tl_a_mask(tl_a_mask),
    .tl_a_data(tl_a_data), .tl_a_corrupt(tl_a_corrupt), .tl_a_valid(tl_a_valid),
    .tl_a_ready(tl_a_ready), .tl_d_opcode(tl_d_opcode), .tl_d_param(tl_d_param),
    .tl_d_size(tl_d_size), .tl_d_source(tl_d_source), .tl_d_denied(tl_d_denied),
    .tl_d_data(tl_d_data), .tl_d_corrupt(tl_d_corrupt), .tl_d_valid(tl_d_valid),
    .tl_d_ready(tl_d_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    logic        den;
    logic        cor;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0, passes = 0;
  int done_cnt = 0, cmds = 0;
  int stall_put = 0, stall_seen = 0;
  logic always_ready = 1'b0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  // kind: 0 none, 1 Get denied, 2 Put denied, 3 Get corrupt; applied to word index dw
  task automatic build(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len,
                       input logic fill, input logic [31:0] pat, input int kind, input int dw,
                       output logic err);
    logic [31:0] s, d;
    beat_t b;
    err = 1'b0;
    s = {src[31:2], 2'b00};
    d = {dst[31:2], 2'b00};
    for (int i = 0; i < int'(len); i++) begin
      if (!fill) begin
        b.op = 3'd4; b.addr = s; b.data = '0; b.rdata = mem(s);
        b.den = (kind == 1 && i == dw); b.cor = (kind == 3 && i == dw);
        exp_q.push_back(b);
        if (b.den || b.cor) begin err = 1'b1; break; end
      end
      b.op = 3'd0; b.addr = d; b.data = fill ? pat : mem(s); b.rdata = '0;
      b.den = (kind == 2 && i == dw); b.cor = 1'b0;
      exp_q.push_back(b);
      if (b.den) begin err = 1'b1; break; end
      s = s + 32'd4;
      d = d + 32'd4;
    end
  endtask

  // Slave side: drives a_ready and D responses on negedges, checks A beats against exp_q
  initial begin
    logic out, hold, dfire, pend;
    logic [2:0] h_op;
    logic [31:0] h_addr, h_data;
    int dly;
    beat_t cur, pb;
    out = 0; hold = 0; dfire = 0; pend = 0; dly = 0;
    h_op = '0; h_addr = '0; h_data = '0;
    tl_a_ready = 0; tl_d_valid = 0; tl_d_opcode = '0; tl_d_param = '0; tl_d_size = 4'd2;
    tl_d_source = '0; tl_d_denied = 0; tl_d_data = '0; tl_d_corrupt = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        tl_d_valid = 0; pend = 0; out = 0; hold = 0; dfire = 0;
        continue;
      end
      if (dfire) begin tl_d_valid = 0; out = 0; dfire = 0; end
      chk("busy_vs_ready", 96'(busy), 96'(!cmd_ready));
      if (done) done_cnt++;
      if (tl_a_valid) begin
        chk("a_const", {tl_a_param, tl_a_size, tl_a_mask, tl_a_corrupt, tl_a_source},
            {3'd0, 4'd2, 4'hF, 1'b0, 1'b0});
        chk("one_outstanding", 96'(out), 96'(0));
      end
      if (hold)
        chk("a_stable", {tl_a_valid, tl_a_opcode, tl_a_address, tl_a_data}, {1'b1, h_op, h_addr, h_data});
      if (stall_put > 0 && tl_a_valid && tl_a_opcode == 3'd0) begin
        tl_a_ready = 0; stall_put--; stall_seen++;
      end else tl_a_ready = always_ready ? 1'b1 : ($urandom_range(0, 3) != 0);
      hold = tl_a_valid && !tl_a_ready;
      h_op = tl_a_opcode; h_addr = tl_a_address; h_data = tl_a_data;
      if (tl_a_valid && tl_a_ready) begin
        chk("a_expected", 96'(exp_q.size() != 0), 96'(1));
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          chk("a_hdr", {tl_a_opcode, tl_a_address}, {cur.op, cur.addr});
          if (cur.op == 3'd0) chk("a_data", 96'(tl_a_data), 96'(cur.data));
          pb = cur; pend = 1; out = 1;
          dly = always_ready ? 0 : $urandom_range(0, 2);
        end
      end
      if (pend && !tl_d_valid) begin
        if (dly == 0) begin
          tl_d_valid = 1; tl_d_opcode = (pb.op == 3'd4) ? 3'd1 : 3'd0;
          tl_d_data = pb.rdata; tl_d_denied = pb.den; tl_d_corrupt = pb.cor;
          pend = 0;
        end else dly--;
      end
      dfire = tl_d_valid && tl_d_ready;
    end
  end

  task automatic start_cmd(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len,
                           input logic fill, input logic [31:0] pat);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("cmd_ready_wait", 96'(cmd_ready), 96'(1));
    cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_fill = fill; cmd_pattern = pat;
    cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    chk("accept", {busy, cmd_ready, error}, 3'b100);
  endtask

  task automatic finish_cmd(input logic ee, input logic junk, output int n);
    n = 0;
    while (!done && n < 400) begin
      if (junk) begin
        cmd_valid = 1'($urandom_range(0, 1)); cmd_src = $urandom; cmd_dst = $urandom;
        cmd_len = 16'($urandom_range(0, 5));
      end
      @(posedge clk); #1; n++;
    end
    cmd_valid = 0;
    cmds++;
    chk("done_seen", 96'(done), 96'(1));
    chk("error_at_done", 96'(error), 96'(ee));
    chk("all_beats", 96'(exp_q.size()), 96'(0));
    @(posedge clk); #1;
    chk("idle_after_done", {done, cmd_ready, busy, error}, {1'b0, 1'b1, 1'b0, ee});
  endtask

  task automatic run_cmd(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len,
                         input logic fill, input logic [31:0] pat, input int kind, input int dw,
                         input logic junk, output int n);
    logic ee;
    build(src, dst, len, fill, pat, kind, dw, ee);
    start_cmd(src, dst, len, fill, pat);
    finish_cmd(ee, junk, n);
  endtask

  initial begin
    logic e;
    int n;
    build(32'h1000, 32'h2000, 16'd3, 1'b0, 32'h0, 0, 0, e);
    chk("pin_copy_size", 96'(exp_q.size()), 96'(6));
    chk("pin_copy_0", {exp_q[0].op, exp_q[0].addr}, {3'd4, 32'h1000});
    chk("pin_copy_1", {exp_q[1].op, exp_q[1].addr}, {3'd0, 32'h2000});
    chk("pin_copy_4", {exp_q[4].op, exp_q[4].addr}, {3'd4, 32'h1008});
    chk("pin_copy_5", {exp_q[5].op, exp_q[5].addr, exp_q[5].data}, {3'd0, 32'h2008, mem(32'h1008)});
    exp_q.delete();
    build(32'hFFFFFFFC, 32'h5000, 16'd2, 1'b0, 32'h0, 0, 0, e);
    chk("pin_wrap", 96'(exp_q[2].addr), 96'(32'h0));
    exp_q.delete();
    build(32'h1003, 32'h2002, 16'd1, 1'b0, 32'h0, 0, 0, e);
    chk("pin_align", {exp_q[0].addr, exp_q[1].addr}, {32'h1000, 32'h2000});
    exp_q.delete();
    build(32'h1000, 32'h2000, 16'd4, 1'b0, 32'h0, 1, 1, e);
    chk("pin_deny", {28'(exp_q.size()), exp_q[2].den, e}, {28'd3, 1'b1, 1'b1});
    exp_q.delete();

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {cmd_ready, done, error, busy, tl_a_valid, tl_d_ready}, 6'b100000);
    reset_n = 1;
    @(posedge clk); #1;

    always_ready = 1;
    run_cmd(32'h1000, 32'h2000, 16'd3, 1'b0, 32'h0, 0, 0, 1'b1, n);
    chk("copy_latency", 96'(n), 96'(12));
    always_ready = 0;

    run_cmd(32'h1234, 32'h5678, 16'd0, 1'b0, 32'h0, 0, 0, 1'b0, n);
    chk("len0_latency", 96'(n <= 1), 96'(1));

    stall_seen = 0; stall_put = 5;
    run_cmd(32'h4000, 32'h6000, 16'd1, 1'b0, 32'h0, 0, 0, 1'b0, n);
    chk("stall_cycles", {32'(stall_seen), 32'(stall_put)}, {32'd5, 32'd0});

    run_cmd(32'h1000, 32'h2000, 16'd4, 1'b0, 32'h0, 1, 1, 1'b0, n);
    run_cmd(32'hFFFFFFFC, 32'h7000, 16'd2, 1'b0, 32'h0, 0, 0, 1'b0, n);
    run_cmd(32'h8000, 32'h9000, 16'd3, 1'b0, 32'h0, 2, 2, 1'b0, n);
    run_cmd(32'h1003, 32'h2001, 16'd2, 1'b0, 32'h0, 3, 1, 1'b0, n);

    build(32'hA000, 32'hB000, 16'd8, 1'b0, 32'h0, 0, 0, e);
    start_cmd(32'hA000, 32'hB000, 16'd8, 1'b0, 32'h0);
    repeat (6) @(posedge clk);
    #1;
    reset_n = 0;
    @(posedge clk); #1;
    chk("mid_reset", {cmd_ready, done, error, busy, tl_a_valid, tl_d_ready}, 6'b100000);
    exp_q.delete();
    reset_n = 1;
    @(posedge clk); #1;

    for (int k = 0; k < 12; k++) begin
      logic [15:0] len;
      int kind;
      len = 16'($urandom_range(0, 6));
      kind = $urandom_range(0, 5);
      run_cmd($urandom, $urandom, len, 1'b0, 32'h0, kind > 3 ? 0 : kind,
              $urandom_range(0, int'(len)), 1'b0, n);
    end

`ifdef DMA_FILL_EN
    build(32'h0, 32'h3000, 16'd2, 1'b1, 32'hDEADBEEF, 0, 0, e);
    chk("pin_fill", {exp_q[0].addr, exp_q[1].addr, exp_q[1].data}, {32'h3000, 32'h3004, 32'hDEADBEEF});
    exp_q.delete();
    run_cmd(32'h0, 32'h3000, 16'd2, 1'b1, 32'hDEADBEEF, 0, 0, 1'b0, n);
    run_cmd(32'h0, 32'h3100, 16'd3, 1'b1, 32'hCAFEF00D, 2, 1, 1'b0, n);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("done_count", 96'(done_cnt), 96'(cmds));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
